// File: rtl/onewire_byte_sender_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// onewire_byte_sender_if : FIFO read port between the byte FIFO and the sender
// Rev 1.0
// ---------------------------------------------------------------------------
interface onewire_byte_sender_if;
  logic [7:0] fifo_do;
  logic       fifo_read_ack;
  logic       fifo_busy;
  logic       fifo_do_read;

  modport master (
    input  fifo_do,
    input  fifo_read_ack,
    input  fifo_busy,
    output fifo_do_read
  );

  modport slave (
    output fifo_do,
    output fifo_read_ack,
    output fifo_busy,
    input  fifo_do_read
  );
endinterface
`default_nettype wire

// File: rtl/onewire_byte_sender.sv
`default_nettype none
// ---------------------------------------------------------------------------
// onewire_byte_sender : 1-wire reset/presence, then FIFO bytes as LSB-first write slots
// Rev 1.0
// ---------------------------------------------------------------------------
module onewire_byte_sender #(
  parameter int unsigned CLK_DIV = 50,
  parameter int unsigned T_RSTL  = 480,
  parameter int unsigned T_PDS   = 70,
  parameter int unsigned T_RSTH  = 480,
  parameter int unsigned T_LOW1  = 6,
  parameter int unsigned T_LOW0  = 60,
  parameter int unsigned T_SLOT  = 70
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  onewire_byte_sender_if.master fifo,
  input  logic                  ow_in_i,
  output logic                  ow_drive_low_o,
  output logic                  presence_o,
  output logic                  active_o,
  output logic                  done_o,
  output logic [7:0]            byte_count_o
);

  localparam int unsigned c_presc_w = $clog2(CLK_DIV);
  localparam logic [c_presc_w-1:0] c_presc_max = c_presc_w'(CLK_DIV - 1);
  localparam logic [c_presc_w-1:0] c_presc_one = c_presc_w'(1);
  localparam logic [9:0] c_rstl = 10'(T_RSTL);
  localparam logic [9:0] c_pds  = 10'(T_PDS);
  localparam logic [9:0] c_rsth = 10'(T_RSTH);
  localparam logic [9:0] c_low1 = 10'(T_LOW1);
  localparam logic [9:0] c_low0 = 10'(T_LOW0);
  localparam logic [9:0] c_slot = 10'(T_SLOT);

  localparam logic [2:0] c_st_idle       = 3'd0;
  localparam logic [2:0] c_st_rst_low    = 3'd1;
  localparam logic [2:0] c_st_rst_high   = 3'd2;
  localparam logic [2:0] c_st_fetch      = 3'd3;
  localparam logic [2:0] c_st_fetch_wait = 3'd4;
  localparam logic [2:0] c_st_bit_low    = 3'd5;
  localparam logic [2:0] c_st_bit_rel    = 3'd6;
  localparam logic [2:0] c_st_done       = 3'd7;

  logic [2:0]           state_q, state_d;
  logic [c_presc_w-1:0] presc_q;
  logic [9:0]           us_q;
  logic [1:0]           wait_q;
  logic                 acked_q;
  logic [7:0]           shift_q;
  logic [3:0]           bit_q;
  logic [7:0]           byte_cnt_q;
  logic                 presence_q;
  logic                 ow_q, ow_d;
  logic                 rd_q, rd_d;
  logic                 done_q, done_d;
  logic                 active_q, active_d;

  logic       w_tick;
  logic [9:0] w_us_nx;
  logic [9:0] w_low_us;
  logic [9:0] w_rel_us;

  assign w_tick   = (presc_q == c_presc_max);
  assign w_us_nx  = us_q + 10'd1;
  assign w_low_us = shift_q[0] ? c_low1 : c_low0;
  assign w_rel_us = c_slot - w_low_us;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= c_st_idle;
    else        state_q <= state_d;
  end

  // Timed states leave on the tick that brings the us counter to its target,
  // so every interval is an exact multiple of CLK_DIV cycles.
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_st_idle:       if (start_i) state_d = c_st_rst_low;
      c_st_rst_low:    if (w_tick && w_us_nx == c_rstl) state_d = c_st_rst_high;
      c_st_rst_high:   if (w_tick && w_us_nx == c_rsth)
                         state_d = presence_q ? c_st_fetch : c_st_done;
      c_st_fetch:      if (!fifo.fifo_busy) state_d = c_st_fetch_wait;
      c_st_fetch_wait: begin
        if (acked_q) begin
          if (wait_q == 2'd1) state_d = c_st_bit_low;
        end else if (!fifo.fifo_read_ack && wait_q == 2'd2) begin
          state_d = c_st_done;
        end
      end
      c_st_bit_low:    if (w_tick && w_us_nx == w_low_us) state_d = c_st_bit_rel;
      c_st_bit_rel:    if (w_tick && w_us_nx == w_rel_us)
                         state_d = (bit_q == 4'd7) ? c_st_fetch : c_st_bit_low;
      c_st_done:       state_d = c_st_idle;
      default:         state_d = c_st_idle;
    endcase
  end

  always_comb begin
    ow_d     = (state_d == c_st_rst_low) || (state_d == c_st_bit_low);
    rd_d     = (state_q == c_st_fetch) && (state_d == c_st_fetch_wait);
    done_d   = (state_d == c_st_done);
    active_d = (state_d != c_st_idle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q    <= '0;
      us_q       <= '0;
      wait_q     <= '0;
      acked_q    <= 1'b0;
      shift_q    <= '0;
      bit_q      <= '0;
      byte_cnt_q <= '0;
      presence_q <= 1'b0;
      ow_q       <= 1'b0;
      rd_q       <= 1'b0;
      done_q     <= 1'b0;
      active_q   <= 1'b0;
    end else begin
      ow_q     <= ow_d;
      rd_q     <= rd_d;
      done_q   <= done_d;
      active_q <= active_d;

      if (state_d != state_q) begin
        presc_q <= '0;
        us_q    <= '0;
      end else if (w_tick) begin
        presc_q <= '0;
        us_q    <= w_us_nx;
      end else begin
        presc_q <= presc_q + c_presc_one;
      end

      // After the ack, two more cycles of RAM latency before fifo_do is valid.
      if (state_q != c_st_fetch_wait) begin
        wait_q  <= '0;
        acked_q <= 1'b0;
      end else if (!acked_q && fifo.fifo_read_ack) begin
        wait_q  <= '0;
        acked_q <= 1'b1;
      end else if (wait_q != 2'd3) begin
        wait_q  <= wait_q + 2'd1;
      end

      if (state_q == c_st_idle && start_i) begin
        presence_q <= 1'b0;
        byte_cnt_q <= '0;
      end else if (state_q == c_st_rst_high && us_q == c_pds && presc_q == '0) begin
        presence_q <= ~ow_in_i;
      end else if (state_q == c_st_fetch_wait && state_d == c_st_bit_low) begin
        byte_cnt_q <= byte_cnt_q + 8'd1;
      end

      if (state_q == c_st_fetch_wait && state_d == c_st_bit_low) begin
        shift_q <= fifo.fifo_do;
        bit_q   <= '0;
      end else if (state_q == c_st_bit_rel && state_d != c_st_bit_rel) begin
        shift_q <= {1'b0, shift_q[7:1]};
        bit_q   <= bit_q + 4'd1;
      end
    end
  end

  assign fifo.fifo_do_read = rd_q;
  assign ow_drive_low_o    = ow_q;
  assign presence_o        = presence_q;
  assign active_o          = active_q;
  assign done_o            = done_q;
  assign byte_count_o      = byte_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_onewire_byte_sender.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_onewire_byte_sender : directed bench with a 1-wire device, FIFO model and slot monitor
// Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_onewire_byte_sender;
  localparam int CLK_DIV = 4;
  localparam int US      = CLK_DIV;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start_i = 1'b0;
  logic       ow_in_i;
  logic       ow_drive_low_o, presence_o, active_o, done_o;
  logic [7:0] byte_count_o;

  onewire_byte_sender_if fif ();

  onewire_byte_sender #(.CLK_DIV(CLK_DIV)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start_i        (start_i),
    .fifo           (fif),
    .ow_in_i        (ow_in_i),
    .ow_drive_low_o (ow_drive_low_o),
    .presence_o     (presence_o),
    .active_o       (active_o),
    .done_o         (done_o),
    .byte_count_o   (byte_count_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Device: answers a long reset low with a presence pulse 15..75 us after release.
  logic dev_present = 1'b0;
  logic dev_prev    = 1'b0;
  logic rel_act     = 1'b0;
  int   low_cnt     = 0;
  int   rel_cnt     = 0;
  logic dev_pull;
  assign dev_pull = rel_act && (rel_cnt >= 15*US) && (rel_cnt < 75*US);
  assign ow_in_i  = ~(ow_drive_low_o | dev_pull);

  always @(posedge clk) begin
    dev_prev <= ow_drive_low_o;
    if (ow_drive_low_o && !dev_prev) low_cnt <= 1;
    else if (ow_drive_low_o)         low_cnt <= low_cnt + 1;
    if (dev_prev && !ow_drive_low_o && low_cnt >= 400*US && dev_present) begin
      rel_act <= 1'b1;
      rel_cnt <= 0;
    end else if (rel_act) begin
      rel_cnt <= rel_cnt + 1;
      if (rel_cnt >= 100*US) rel_act <= 1'b0;
    end
  end

  // FIFO model: ack one cycle after a read request, data held until the next pop.
  logic [7:0] fifo_q[$];
  int   rd_cycs[$];
  int   pc = 0, n_ack = 0, n_nack = 0, n_viol = 0, drop_cyc = -1;
  logic busy_prev = 1'b0, rd_prev = 1'b0;

  always @(posedge clk) begin
    fif.fifo_read_ack <= 1'b0;
    if (!fif.fifo_busy && busy_prev) drop_cyc = pc;
    if (fif.fifo_do_read) begin
      rd_cycs.push_back(pc);
      if (fif.fifo_busy || rd_prev) n_viol++;
      if (fifo_q.size() > 0) begin
        fif.fifo_read_ack <= 1'b1;
        fif.fifo_do       <= fifo_q.pop_front();
        n_ack++;
      end else begin
        n_nack++;
      end
    end
    busy_prev = fif.fifo_busy;
    rd_prev   = fif.fifo_do_read;
    pc++;
  end

  // Bus monitor: low pulses longer than 1000 cycles are reset pulses, the rest are slots.
  int   cyc = 0, rise_t = 0, rst_len = 0, rst_cnt = 0;
  int   lows[$], rises[$];
  logic mon_prev = 1'b0;

  always @(negedge clk) begin
    if (ow_drive_low_o && !mon_prev) rise_t = cyc;
    if (!ow_drive_low_o && mon_prev) begin
      if (cyc - rise_t > 1000) begin
        rst_len = cyc - rise_t;
        rst_cnt++;
      end else begin
        lows.push_back(cyc - rise_t);
        rises.push_back(rise_t);
      end
    end
    mon_prev = ow_drive_low_o;
    cyc++;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max_cyc, output int lat);
    int got;
    got = 0;
    lat = 0;
    for (int i = 0; i < max_cyc && got == 0; i++) begin
      step();
      lat++;
      if (done_o) got = 1;
    end
    check_eq({tag, "_done"}, got, 1);
  endtask

  function automatic logic [7:0] decode(input int k);
    logic [7:0] b;
    b = '0;
    for (int i = 0; i < 8; i++)
      if (k + i < lows.size()) b[i] = (lows[k + i] < 30*US);
    return b;
  endfunction

  initial begin
    int lat, k, base_l, n_rd0, n_ack0, n_nack0, gap;
    int exp_low[8];
    logic [7:0] exp_bytes[3];
    exp_low   = '{24, 240, 24, 240, 240, 24, 240, 24};
    exp_bytes = '{8'h00, 8'hFF, 8'h3C};
    fif.fifo_busy = 1'b0;

    #2 rst_n = 1'b0;
    repeat (3) step();
    check_eq("rst_drive",    ow_drive_low_o,   0);
    check_eq("rst_active",   active_o,         0);
    check_eq("rst_done",     done_o,           0);
    check_eq("rst_presence", presence_o,       0);
    check_eq("rst_bytecnt",  byte_count_o,     0);
    check_eq("rst_rdreq",    fif.fifo_do_read, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) step();

    // 1: device present, FIFO empty
    dev_present = 1'b1;
    base_l = lows.size(); n_ack0 = n_ack; n_nack0 = n_nack; k = rst_cnt;
    pulse_start();
    step();
    check_eq("t1_active", active_o, 1);
    check_eq("t1_drive",  ow_drive_low_o, 1);
    wait_done("t1", 6000, lat);
    check_eq("t1_rst_pulses", rst_cnt - k, 1);
    check_eq("t1_rst_len_ok", (rst_len >= 1916 && rst_len <= 1924), 1);
    check_eq("t1_presence", presence_o, 1);
    check_eq("t1_bits", lows.size() - base_l, 0);
    check_eq("t1_bytecnt", byte_count_o, 0);
    check_eq("t1_nack_reads", n_nack - n_nack0, 1);
    check_eq("t1_ack_reads", n_ack - n_ack0, 0);
    step();
    check_eq("t1_idle_active", active_o, 0);

    // 2: no device; a byte waits in the FIFO and must not be touched
    dev_present = 1'b0;
    fifo_q.push_back(8'hA5);
    n_rd0 = rd_cycs.size();
    pulse_start();
    wait_done("t2", 6000, lat);
    check_eq("t2_presence", presence_o, 0);
    check_eq("t2_latency_ok", (lat >= 3839 && lat <= 3843), 1);
    check_eq("t2_reads", rd_cycs.size() - n_rd0, 0);
    check_eq("t2_fifo_left", fifo_q.size(), 1);
    repeat (3) step();

    // 3: device present, 0xA5 sent LSB first
    dev_present = 1'b1;
    base_l = lows.size();
    pulse_start();
    wait_done("t3", 8000, lat);
    check_eq("t3_nbits", lows.size() - base_l, 8);
    check_eq("t3_byte", decode(base_l), 8'hA5);
    for (int i = 0; i < 8; i++)
      if (base_l + i < lows.size())
        check_eq($sformatf("t3_low%0d", i), lows[base_l + i], exp_low[i]);
    for (int i = 0; i < 7; i++)
      if (base_l + i + 1 < rises.size())
        check_eq($sformatf("t3_slot%0d", i), rises[base_l + i + 1] - rises[base_l + i], 280);
    check_eq("t3_bytecnt", byte_count_o, 1);
    repeat (3) step();

    // 4: three bytes back to back
    fifo_q.push_back(8'h00); fifo_q.push_back(8'hFF); fifo_q.push_back(8'h3C);
    base_l = lows.size(); n_ack0 = n_ack; n_nack0 = n_nack;
    pulse_start();
    wait_done("t4", 14000, lat);
    check_eq("t4_nbits", lows.size() - base_l, 24);
    for (int b = 0; b < 3; b++)
      check_eq($sformatf("t4_byte%0d", b), decode(base_l + 8*b), exp_bytes[b]);
    check_eq("t4_ack_reads", n_ack - n_ack0, 3);
    check_eq("t4_nack_reads", n_nack - n_nack0, 1);
    check_eq("t4_bytecnt", byte_count_o, 3);
    if (base_l + 8 < rises.size()) begin
      gap = rises[base_l + 8] - rises[base_l + 7];
      check_eq("t4_byte_gap_ok", (gap >= 280 && gap <= 288), 1);
    end
    repeat (3) step();

    // 5: FIFO busy across the fetch point
    fifo_q.push_back(8'h96);
    fif.fifo_busy = 1'b1;
    base_l = lows.size(); n_rd0 = rd_cycs.size();
    pulse_start();
    repeat (3860) step();
    check_eq("t5_no_read_busy", rd_cycs.size() - n_rd0, 0);
    fif.fifo_busy = 1'b0;
    wait_done("t5", 6000, lat);
    check_eq("t5_reads", rd_cycs.size() - n_rd0, 2);
    if (rd_cycs.size() > n_rd0)
      check_eq("t5_read_after_drop", rd_cycs[n_rd0] - drop_cyc, 1);
    check_eq("t5_byte", decode(base_l), 8'h96);
    check_eq("t5_bytecnt", byte_count_o, 1);
    repeat (3) step();

    // 6: reset asserted during the low phase of bit 3
    fifo_q.push_back(8'hA5);
    base_l = lows.size();
    pulse_start();
    for (int i = 0; i < 8000 && !(lows.size() == base_l + 3 && ow_drive_low_o); i++) step();
    check_eq("t6_reach_bit3", (lows.size() == base_l + 3 && ow_drive_low_o), 1);
    repeat (5) step();
    rst_n = 1'b0;
    #1;
    check_eq("t6_drive", ow_drive_low_o, 0);
    check_eq("t6_active", active_o, 0);
    check_eq("t6_presence", presence_o, 0);
    check_eq("t6_bytecnt", byte_count_o, 0);
    repeat (3) step();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) step();
    base_l = lows.size(); k = rst_cnt;
    pulse_start();
    wait_done("t6b", 6000, lat);
    check_eq("t6b_rst_pulses", rst_cnt - k, 1);
    check_eq("t6b_rst_len_ok", (rst_len >= 1916 && rst_len <= 1924), 1);
    check_eq("t6b_presence", presence_o, 1);
    check_eq("t6b_bits", lows.size() - base_l, 0);
    check_eq("t6b_bytecnt", byte_count_o, 0);

    check_eq("read_protocol_violations", n_viol, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
